// File: rtl/core_run_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_run_pkg
// Description : Shared state encoding and constants for the core run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package core_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  localparam logic [31:0] c_TOHOST_ADDR = 32'h0000_0FFC;
  localparam logic [31:0] c_PASS_VALUE  = 32'd1;

endpackage
`default_nettype wire

// File: rtl/core_run_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module      : run_cycle_counter
// Description : Saturating up-counter with clear, enable and terminal compare.
// Revision    : 1.0 - initial release
// ============================================================================
module run_cycle_counter
  import core_run_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_count,
  output logic             o_term
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == i_term);

endmodule
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_run_ctrl
// Description : Sequences core reset, runs the core, and ends the run on a
//               tohost store or watchdog timeout. Optional PC self-loop stall
//               detection is enabled by defining CORE_RUN_STALL_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int                RST_CYCLES     = 4,
  parameter int                CNT_W          = 32,
  parameter int                TIMEOUT_CYCLES = 100000,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(c_TOHOST_ADDR),
  parameter int                STALL_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_core_rst,
  output logic              o_running,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [DATA_W-1:0] o_fail_code,
  output logic [CNT_W-1:0]  o_cycle_count
`ifdef CORE_RUN_STALL_DETECT_EN
  ,
  output logic              o_stalled
`endif
);

  localparam int c_RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_e        r_state;
  run_state_e        w_next;
  logic              w_start_go;
  logic              w_store;
  logic              w_pass_store;
  logic              w_stall_hit;
  logic              w_rst_term;
  logic              w_cyc_term;
  logic [c_RST_W-1:0] w_rst_cnt_unused;

  logic              r_core_rst;
  logic              r_running;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic [DATA_W-1:0] r_fail_code;

  assign w_start_go   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // A zero write to tohost is not a completion; it lets programs clear the slot.
  assign w_store      = i_mem_we && (i_mem_addr == TOHOST_ADDR) && (i_mem_wdata != '0);
  assign w_pass_store = (i_mem_wdata == DATA_W'(c_PASS_VALUE));

  run_cycle_counter #(.CNT_W(c_RST_W)) u_rst_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start_go),
    .i_en    (r_state == ST_RESET),
    .i_term  (c_RST_W'(RST_CYCLES - 1)),
    .o_count (w_rst_cnt_unused),
    .o_term  (w_rst_term)
  );

  run_cycle_counter #(.CNT_W(CNT_W)) u_cycle_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start_go),
    .i_en    (r_state == ST_RUN),
    .i_term  (CNT_W'(TIMEOUT_CYCLES - 1)),
    .o_count (o_cycle_count),
    .o_term  (w_cyc_term)
  );

`ifdef CORE_RUN_STALL_DETECT_EN
  localparam int c_STALL_W = $clog2(STALL_CYCLES + 1);

  logic [ADDR_W-1:0]    r_prev_pc;
  logic                 r_pc_valid;
  logic [c_STALL_W-1:0] r_stall_cnt;
  logic                 r_stalled;
  logic                 w_pc_repeat;

  assign w_pc_repeat = (r_state == ST_RUN) && r_pc_valid && (i_pc == r_prev_pc);
  assign w_stall_hit = w_pc_repeat && (r_stall_cnt == c_STALL_W'(STALL_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_pc   <= '0;
      r_pc_valid  <= 1'b0;
      r_stall_cnt <= '0;
    end else if (r_state != ST_RUN) begin
      r_pc_valid  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_prev_pc   <= i_pc;
      r_pc_valid  <= 1'b1;
      r_stall_cnt <= w_pc_repeat ? (r_stall_cnt + c_STALL_W'(1)) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stalled <= 1'b0;
    end else if (w_start_go) begin
      r_stalled <= 1'b0;
    end else if ((r_state == ST_RUN) && !w_store && w_stall_hit) begin
      r_stalled <= 1'b1;
    end
  end

  assign o_stalled = r_stalled;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^{i_pc, (STALL_CYCLES > 0)};
  assign w_stall_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_RESET;
      ST_RESET: if (w_rst_term) w_next = ST_RUN;
      ST_RUN:   if (w_store || w_stall_hit || w_cyc_term) w_next = ST_DONE;
      ST_DONE:  if (i_start) w_next = ST_RESET;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Control outputs follow the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_rst  <= 1'b1;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail_code <= '0;
    end else begin
      r_core_rst <= (w_next != ST_RUN);
      r_running  <= (w_next == ST_RUN);
      r_done     <= (w_next == ST_DONE);
      if (w_start_go) begin
        r_pass      <= 1'b0;
        r_timeout   <= 1'b0;
        r_fail_code <= '0;
      end else if (r_state == ST_RUN) begin
        if (w_store) begin
          r_pass      <= w_pass_store;
          r_fail_code <= w_pass_store ? '0 : (i_mem_wdata >> 1);
        end else if (!w_stall_hit && w_cyc_term) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign o_core_rst  = r_core_rst;
  assign o_running   = r_running;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_timeout   = r_timeout;
  assign o_fail_code = r_fail_code;

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_run_ctrl
// Description : Self-checking bench for core_run_ctrl (directed table, random
//               runs against a reference model, mid-run reset, optional stall).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_run_ctrl;

  localparam int          RST_CYCLES = 4;
  localparam int          TIMEOUT    = 20;
  localparam int          MAXC       = 64;
  localparam logic [31:0] TOHOST     = 32'h0000_0FFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] pc;
  logic        core_rst;
  logic        running;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] fail_code;
  logic [31:0] cycle_count;
`ifdef CORE_RUN_STALL_DETECT_EN
  logic        stalled;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus per RUN cycle, indexed by RUN cycle number (1-based).
  logic        s_we   [0:MAXC-1];
  logic [31:0] s_addr [0:MAXC-1];
  logic [31:0] s_data [0:MAXC-1];
  logic [31:0] s_pc   [0:MAXC-1];

  typedef struct {
    int          zero_cyc;
    int          store_cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_count;
    logic        exp_pass;
    logic        exp_timeout;
    logic [31:0] exp_fail;
  } vec_t;

  vec_t vecs[8];

  core_run_ctrl #(
    .RST_CYCLES     (RST_CYCLES),
    .CNT_W          (32),
    .TIMEOUT_CYCLES (TIMEOUT),
    .ADDR_W         (32),
    .DATA_W         (32),
    .TOHOST_ADDR    (TOHOST),
    .STALL_CYCLES   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (start),
    .i_mem_we      (mem_we),
    .i_mem_addr    (mem_addr),
    .i_mem_wdata   (mem_wdata),
    .i_pc          (pc),
    .o_core_rst    (core_rst),
    .o_running     (running),
    .o_done        (done),
    .o_pass        (pass),
    .o_timeout     (timeout),
    .o_fail_code   (fail_code),
    .o_cycle_count (cycle_count)
`ifdef CORE_RUN_STALL_DETECT_EN
    ,
    .o_stalled     (stalled)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sched();
    for (int k = 0; k < MAXC; k++) begin
      s_we[k]   = 1'($urandom % 2);
      s_addr[k] = 32'h1000 + 32'(($urandom % 64) * 4);
      s_data[k] = $urandom;
      s_pc[k]   = 32'h100 + 32'(k * 4);
    end
  endtask

  task automatic do_run(input string tag, input int exp_count, input logic exp_pass,
                        input logic exp_timeout, input logic [31:0] exp_fail,
                        input logic exp_stalled);
    int k;
    bit fin;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < RST_CYCLES; r++) begin
      chk({tag, "/reset_core_rst"}, core_rst, 1'b1);
      chk({tag, "/reset_running"}, running, 1'b0);
      start     = 1'($urandom % 2);
      mem_we    = 1'b1;
      mem_addr  = TOHOST;
      mem_wdata = 32'd1;
      tick();
    end
    start  = 1'b0;
    mem_we = 1'b0;
    chk({tag, "/run_core_rst"}, core_rst, 1'b0);
    k   = 1;
    fin = 0;
    while (!fin && k <= TIMEOUT + 2) begin
      chk({tag, "/run_count"}, cycle_count, 64'(k - 1));
      chk({tag, "/run_running"}, running, 1'b1);
      chk({tag, "/run_done"}, done, 1'b0);
      mem_we    = s_we[k];
      mem_addr  = s_addr[k];
      mem_wdata = s_data[k];
      pc        = s_pc[k];
      start     = ($urandom % 4 == 0);
      tick();
      start = 1'b0;
      if (done) fin = 1;
      else k++;
    end
    chk({tag, "/done_within_bound"}, done, 1'b1);
    chk({tag, "/final_count"}, cycle_count, 64'(exp_count));
    chk({tag, "/pass"}, pass, exp_pass);
    chk({tag, "/timeout"}, timeout, exp_timeout);
    chk({tag, "/fail_code"}, fail_code, exp_fail);
    chk({tag, "/done_core_rst"}, core_rst, 1'b1);
    chk({tag, "/done_running"}, running, 1'b0);
`ifdef CORE_RUN_STALL_DETECT_EN
    chk({tag, "/stalled"}, stalled, exp_stalled);
`endif
    mem_we    = 1'b1;
    mem_addr  = TOHOST;
    mem_wdata = 32'h5;
    tick();
    tick();
    mem_we = 1'b0;
    chk({tag, "/hold_done"}, done, 1'b1);
    chk({tag, "/hold_count"}, cycle_count, 64'(exp_count));
    chk({tag, "/hold_pass"}, pass, exp_pass);
    chk({tag, "/hold_fail_code"}, fail_code, exp_fail);
  endtask

  initial begin
    int          ec;
    logic        ep;
    logic        et;
    logic [31:0] ef;
    bit          found;

    rst = 1'b1; start = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; pc = '0;
    #3;
    chk("reset/core_rst", core_rst, 1'b1);
    chk("reset/running", running, 1'b0);
    chk("reset/done", done, 1'b0);
    chk("reset/pass", pass, 1'b0);
    chk("reset/timeout", timeout, 1'b0);
    chk("reset/fail_code", fail_code, 32'd0);
    chk("reset/count", cycle_count, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    tick();
    chk("idle/core_rst", core_rst, 1'b1);
    chk("idle/running", running, 1'b0);

    vecs[0] = '{0, 10, 1'b1, TOHOST, 32'd1, 10, 1'b1, 1'b0, 32'd0};
    vecs[1] = '{3, 6, 1'b1, TOHOST, 32'd7, 6, 1'b0, 1'b0, 32'd3};
    vecs[2] = '{0, 0, 1'b0, TOHOST, 32'd1, 20, 1'b0, 1'b1, 32'd0};
    vecs[3] = '{5, 20, 1'b1, TOHOST, 32'd1, 20, 1'b1, 1'b0, 32'd0};
    vecs[4] = '{0, 1, 1'b1, TOHOST, 32'hFFFF_FFFE, 1, 1'b0, 1'b0, 32'h7FFF_FFFF};
    vecs[5] = '{0, 5, 1'b1, 32'h0000_0FF8, 32'd1, 20, 1'b0, 1'b1, 32'd0};
    vecs[6] = '{0, 19, 1'b1, TOHOST, 32'd2, 19, 1'b0, 1'b0, 32'd1};
    vecs[7] = '{0, 8, 1'b0, TOHOST, 32'd1, 20, 1'b0, 1'b1, 32'd0};

    for (int v = 0; v < 8; v++) begin
      clear_sched();
      if (vecs[v].zero_cyc != 0) begin
        s_we[vecs[v].zero_cyc]   = 1'b1;
        s_addr[vecs[v].zero_cyc] = TOHOST;
        s_data[vecs[v].zero_cyc] = 32'd0;
      end
      if (vecs[v].store_cyc != 0) begin
        s_we[vecs[v].store_cyc]   = vecs[v].we;
        s_addr[vecs[v].store_cyc] = vecs[v].addr;
        s_data[vecs[v].store_cyc] = vecs[v].data;
      end
      do_run($sformatf("vec%0d", v), vecs[v].exp_count, vecs[v].exp_pass,
             vecs[v].exp_timeout, vecs[v].exp_fail, 1'b0);
    end

    for (int t = 0; t < 25; t++) begin
      clear_sched();
      for (int k = 1; k <= TIMEOUT; k++) begin
        if ($urandom % 6 == 0) begin
          s_addr[k] = TOHOST;
          s_we[k]   = ($urandom % 3 != 0);
          case ($urandom % 4)
            0:       s_data[k] = 32'd0;
            1:       s_data[k] = 32'd1;
            default: s_data[k] = $urandom;
          endcase
        end
      end
      // Reference: the first nonzero store to tohost ends the run, else timeout.
      found = 0; ec = TIMEOUT; ep = 1'b0; et = 1'b1; ef = '0;
      for (int k = 1; k <= TIMEOUT; k++) begin
        if (!found && s_we[k] && s_addr[k] == TOHOST && s_data[k] != 0) begin
          found = 1;
          ec    = k;
          et    = 1'b0;
          ep    = (s_data[k] == 1);
          ef    = ep ? 32'd0 : (s_data[k] >> 1);
        end
      end
      do_run($sformatf("rand%0d", t), ec, ep, et, ef, 1'b0);
    end

    clear_sched();
    mem_we = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (RST_CYCLES) tick();
    for (int k = 1; k <= 4; k++) begin
      pc = 32'h200 + 32'(k * 4);
      tick();
    end
    chk("midrst/count_before", cycle_count, 32'd4);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst/core_rst", core_rst, 1'b1);
    chk("midrst/running", running, 1'b0);
    chk("midrst/done", done, 1'b0);
    chk("midrst/pass", pass, 1'b0);
    chk("midrst/timeout", timeout, 1'b0);
    chk("midrst/fail_code", fail_code, 32'd0);
    chk("midrst/count", cycle_count, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst/idle_core_rst", core_rst, 1'b1);
    s_we[10] = 1'b1; s_addr[10] = TOHOST; s_data[10] = 32'd1;
    do_run("restart", 10, 1'b1, 1'b0, 32'd0, 1'b0);

`ifdef CORE_RUN_STALL_DETECT_EN
    clear_sched();
    for (int k = 3; k < MAXC; k++) s_pc[k] = 32'h40;
    do_run("stall", 11, 1'b0, 1'b0, 32'd0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
